// File: rtl/hack_rom_loader.sv
// hack_rom_loader
//
// Fills the Hack CPU instruction ROM from a byte stream and keeps the CPU in
// reset until the load has finished.
//
// Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N words,
// each sent as high byte then low byte. Word i is written to ROM address i.
//
// Handshake: a byte moves from the source to the loader on a rising clock
// edge where in_valid and in_ready are both high. The source must hold
// in_data stable while in_valid is high and in_ready is low. The loader never
// looks at in_data outside a transfer, and in_valid may drop at any time
// without penalty (the FSM simply waits).
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   start        one-cycle pulse; begins a load from IDLE or DONE only
//   in_data      stream byte
//   in_valid     in_data is valid
//   in_ready     loader accepts a byte this cycle
//   rom_we       ROM write strobe, one cycle per word
//   rom_addr     ROM write address
//   rom_wdata    instruction word {hi, lo}
//   cpu_rst      CPU reset, high until a load completes without error
//   busy         load in progress
//   done         last load completed successfully
//   err          last load rejected (N larger than ROM capacity)
//   word_count   words written by the current or last load
//   dbg_state    current FSM state, for observation only

module hack_rom_loader #(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [15:0]       rom_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_HI  = 3'd1;
    localparam logic [2:0] S_LEN_LO  = 3'd2;
    localparam logic [2:0] S_DATA_HI = 3'd3;
    localparam logic [2:0] S_DATA_LO = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    // Capacity needs one bit more than the length field so that a full
    // 16-bit ROM (ADDR_W=16) still compares correctly.
    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

    logic [2:0]  state;
    logic [15:0] len_q;
    logic [7:0]  hi_q;
    logic        xfer;
    logic [15:0] len_full;

    assign xfer      = in_valid & in_ready;
    // Full length as it becomes known during the LEN_LO transfer.
    assign len_full  = {len_q[15:8], in_data};
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            len_q      <= '0;
            hi_q       <= '0;
            in_ready   <= 1'b0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_wdata  <= '0;
            cpu_rst    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
        end else begin
            rom_we <= 1'b0;

            // word_count doubles as the address counter; it advances on the
            // edge that closes the write cycle. A back-to-back stream needs
            // at least one more byte (DATA_HI) before the next DATA_LO, so
            // the count is always current when the next word is compared.
            if (rom_we) begin
                word_count <= word_count + 16'd1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (state == S_DONE) begin
                        done    <= ~err;
                        cpu_rst <= err;
                    end
                    if (start) begin
                        state      <= S_LEN_HI;
                        in_ready   <= 1'b1;
                        busy       <= 1'b1;
                        cpu_rst    <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                        rom_addr   <= '0;
                    end
                end

                S_LEN_HI: begin
                    if (xfer) begin
                        len_q[15:8] <= in_data;
                        state       <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= in_data;
                        if (len_full == 16'd0) begin
                            // Nothing to write: release the CPU right away.
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            cpu_rst  <= 1'b0;
                        end else if ({1'b0, len_full} > CAPACITY) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            err      <= 1'b1;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                end

                S_DATA_HI: begin
                    if (xfer) begin
                        hi_q  <= in_data;
                        state <= S_DATA_LO;
                    end
                end

                S_DATA_LO: begin
                    if (xfer) begin
                        rom_we    <= 1'b1;
                        rom_wdata <= {hi_q, in_data};
                        rom_addr  <= word_count[ADDR_W-1:0];
                        // DONE is entered together with the last write, so
                        // cpu_rst drops only on the following edge.
                        if (word_count + 16'd1 == len_q) begin
                            state    <= S_DONE;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Writes instruction memory for the Hack CPU; it is the producer of the 16-bit instruction words that the CPU fetches and decodes.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver.
- Packs byte pairs into Hack instructions, writes them to ROM at consecutive addresses from 0, and holds the CPU in reset until a load completes.

Parameters:
- ADDR_W, 15, ROM address width; capacity is 2**ADDR_W words.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle; a transfer happens when in_valid & in_ready.
- rom_we  output  1  ROM write strobe, one cycle per word.
- rom_addr  output  ADDR_W  ROM write address.
- rom_wdata  output  16  instruction word; bit 15 = 0 for an A-instruction, 1 for a C-instruction.
- cpu_rst  output  1  holds the CPU in reset while high.
- busy  output  1  a load is in progress.
- done  output  1  the last load completed successfully.
- err  output  1  the last load was rejected because the length exceeds capacity.
- word_count  output  16  number of words written by the current or last load.

Behaviour:
- Reset values (all registered outputs, reset synchronous on rst): state=IDLE, in_ready=0, rom_we=0, rom_addr=0, rom_wdata=0, cpu_rst=1, busy=0, done=0, err=0, word_count=0.
- Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N words, each sent as high byte then low byte.
- State IDLE: in_ready=0. On start go to LEN_HI; clear done, err, word_count and the address counter; set busy=1 and cpu_rst=1.
- State LEN_HI: in_ready=1. On transfer, latch N[15:8] and go to LEN_LO.
- State LEN_LO: in_ready=1. On transfer, latch N[7:0], then:
  - N==0: go to DONE.
  - N > 2**ADDR_W: set err=1 and go to DONE.
  - Otherwise: go to DATA_HI.
- State DATA_HI: in_ready=1. On transfer, latch the high byte and go to DATA_LO.
- State DATA_LO: in_ready=1. On transfer, on the next cycle drive:
  - rom_we=1 for exactly one cycle;
  - rom_wdata = {hi, lo};
  - rom_addr = current address.
  - The address counter and word_count increment after the write.
  - If word_count+1 == N, go to DONE; otherwise go to DATA_HI.
- Write latency is 1 cycle after the low-byte transfer. in_ready stays high during the write cycle, so a back-to-back stream sustains 1 byte per clock.
- State DONE: in_ready=0, busy=0. When err=0, hold done=1 and cpu_rst=0. When err=1, hold done=0 and cpu_rst=1. The CPU stays in reset after a rejected load.
  - DONE is entered on the same edge that issues the last rom_we, so the write completes before cpu_rst falls. cpu_rst falls one cycle after the last rom_we.
- start while busy is ignored; the load continues.
- start in DONE begins a new load: same actions as from IDLE, and cpu_rst re-asserts on the next cycle.
- Bytes presented with in_valid high while in_ready is low (IDLE/DONE) are not consumed.
- in_valid gaps at any point stall the FSM indefinitely. Outputs hold; rom_we=0 during stalls.
- Address arithmetic:
  - rom_addr is ADDR_W bits and never wraps, because N is bounded by 2**ADDR_W.
  - N == 2**ADDR_W is accepted; the last write goes to address 2**ADDR_W-1.
  - word_count is 16 bits; for ADDR_W=15 the maximum is 32768.
- rst asserted mid-load: return to the reset values on the next edge. No rom_we is issued on that edge. ROM contents already written are left as-is.
- rst and start asserted together: rst wins.

Test Plan:
- Load N=2 with bytes 00 02 00 07 EC 10:
  - rom_we pulses twice: addr 0 / data 0x0007, then addr 1 / data 0xEC10.
  - On the cycle after the second rom_we: done=1, cpu_rst=0, word_count=2.
- Back-to-back stream (in_valid held high) of N=3: in_ready never drops, exactly 3 rom_we pulses, and the load completes in 8 accepted bytes plus 1 cycle.
- N=0 (bytes 00 00): no rom_we; done=1 and cpu_rst=0 on the cycle after the LEN_LO transfer.
- ADDR_W=4 with N=17 (00 11): err=1, done=0, cpu_rst=1, no rom_we, in_ready=0 afterwards. Then start followed by a valid N=1 load clears err and sets done.
- Random in_valid gaps during N=4 (words 0x0001..0x0004): writes land at addr 0..3 with correct data, and rom_we=0 during every stall cycle.
- rst after the 3rd data byte of an N=2 load: all outputs return to reset values next cycle. A following start and full N=2 load writes addr 0 and 1 correctly.
